// File: rtl/fib_seq_pkg.sv
// Shared types and constants for the Fibonacci seven-segment display path.
package fib_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIB,
    S_CONV,
    S_LOAD,
    S_DWELL
  } state_t;

  // Full 8-bit digit patterns, {dp,g,f,e,d,c,b,a}, active low.
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  // BCD digit to active-low {g,f,e,d,c,b,a}; codes above 9 go dark.
  function automatic logic [6:0] bcd_to_sseg_n(input logic [3:0] dig);
    logic [6:0] seg;
    case (dig)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bcd_shift_add3.sv
// Sequential double-dabble converter: one shift-add-3 step per cycle,
// BIN_W steps per conversion. done_o marks the final step; bcd_o holds
// the finished result from the following cycle until the next start.
module bcd_shift_add3 #(
  parameter int BIN_W  = 19,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [BIN_W-1:0]      bin_i,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  logic [BIN_W-1:0] bin_q;
  logic [BCD_W-1:0] bcd_q, adj;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  assign done_o = busy_q && (cnt_q == CNT_W'(BIN_W - 1));
  assign bcd_o  = bcd_q;

  // Add 3 to every digit that is 5 or more before the shift.
  always_comb begin
    adj = bcd_q;
    for (int d = 0; d < DIGITS; d++)
      if (adj[4*d +: 4] > 4'd4) adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
  end

  // Load on start, then shift the binary MSB into the adjusted BCD each cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      bin_q  <= bin_i;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      bcd_q  <= BCD_W'({adj, bin_q[BIN_W-1]});
      bin_q  <= {bin_q[BIN_W-2:0], 1'b0};
      cnt_q  <= cnt_q + 1'b1;
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/fib_seq_display.sv
// Fibonacci display: computes F(n) (or steps F(0)..F(n) in run mode),
// converts to BCD and latches blanked/dashed seven-segment patterns.
module fib_seq_display
  import fib_seq_pkg::*;
#(
  parameter int N_W      = 5,
  parameter int RES_W    = 19,
  parameter int DIGITS   = 6,
  parameter int DWELL    = 25_000_000,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  run_mode,
  input  logic [N_W-1:0]        n,
  output logic [8*DIGITS-1:0]   sseg,
  output logic [N_W-1:0]        leds,
  output logic                  busy,
  output logic                  done_tick,
  output logic                  overflow
);

  localparam int DW_W = $clog2(DWELL + 1);

  if (64'(10) ** DIGITS <= (64'(1) << RES_W) - 64'(1)) begin : g_bad_digits
    $error("DIGITS cannot represent every RES_W-bit value");
  end

  state_t               state_q, state_d;
  logic                 start_q, req;
  logic                 mode_q;
  logic [N_W-1:0]       n_lat_q, k_q;
  logic [RES_W-1:0]     a_q, b_q;
  logic [RES_W:0]       sum;
  logic                 ovf_a_q, ovf_b_q;
  logic [DW_W-1:0]      dwell_q;
  logic                 accept, advance, conv_start, finish, conv_done;
  logic [4*DIGITS-1:0]  bcd;
  logic [3:0]           dig;
  logic                 seen;
  logic [8*DIGITS-1:0]  sseg_d, sseg_q;
  logic                 busy_q, done_q, ovf_disp_q;

  assign req       = start_q & ~start;
  assign sum       = {1'b0, a_q} + {1'b0, b_q};
  assign leds      = n;
  assign sseg      = sseg_q;
  assign busy      = busy_q;
  assign done_tick = done_q;
  assign overflow  = ovf_disp_q;

  bcd_shift_add3 #(.BIN_W(RES_W), .DIGITS(DIGITS)) u_bcd (
    .clk     (clk),
    .reset   (reset),
    .start_i (conv_start),
    .bin_i   (a_q),
    .done_o  (conv_done),
    .bcd_o   (bcd)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state and datapath strobes.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    advance    = 1'b0;
    conv_start = 1'b0;
    finish     = 1'b0;
    case (state_q)
      S_IDLE: if (req) begin
        accept  = 1'b1;
        state_d = S_FIB;
      end
      S_FIB: begin
        // Run mode shows the current a; the step to the next term happens on dwell exit.
        if (mode_q || k_q == n_lat_q) begin
          conv_start = 1'b1;
          state_d    = S_CONV;
        end else begin
          advance = 1'b1;
        end
      end
      S_CONV: if (conv_done) state_d = S_LOAD;
      S_LOAD: begin
        if (!mode_q || k_q == n_lat_q || ovf_a_q) begin
          finish  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_DWELL;
        end
      end
      S_DWELL: if (dwell_q == DW_W'(DWELL - 1)) begin
        advance = 1'b1;
        state_d = S_FIB;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Edge detect, request latch, Fibonacci pair and dwell counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q <= 1'b1;
      mode_q  <= 1'b0;
      n_lat_q <= '0;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ovf_a_q <= 1'b0;
      ovf_b_q <= 1'b0;
      dwell_q <= '0;
    end else begin
      start_q <= start;
      dwell_q <= (state_q == S_DWELL) ? dwell_q + 1'b1 : '0;
      if (accept) begin
        mode_q  <= run_mode;
        n_lat_q <= n;
        k_q     <= '0;
        a_q     <= '0;
        b_q     <= RES_W'(1);
        ovf_a_q <= 1'b0;
        ovf_b_q <= 1'b0;
      end else if (advance) begin
        // Overflow is sticky in b and trails into a one step later.
        a_q     <= b_q;
        b_q     <= sum[RES_W-1:0];
        ovf_b_q <= ovf_b_q | sum[RES_W];
        ovf_a_q <= ovf_b_q;
        k_q     <= k_q + 1'b1;
      end
    end
  end

  // Digit decode with leading-zero blanking; overflow shows dashes everywhere.
  always_comb begin
    sseg_d = '1;
    seen   = 1'b0;
    dig    = '0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      dig  = bcd[4*d +: 4];
      seen = seen | (dig != 4'd0);
      if (ovf_a_q)
        sseg_d[8*d +: 8] = SEG_DASH;
      else if (BLANK_LZ != 0 && !seen && d != 0)
        sseg_d[8*d +: 8] = SEG_BLANK;
      else
        sseg_d[8*d +: 8] = {1'b1, bcd_to_sseg_n(dig)};
    end
  end

  // Output registers; the display only changes in LOAD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sseg_q     <= '1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_disp_q <= 1'b0;
    end else begin
      done_q <= finish;
      if (accept) begin
        busy_q     <= 1'b1;
        ovf_disp_q <= 1'b0;
      end
      if (state_q == S_LOAD) begin
        sseg_q     <= sseg_d;
        ovf_disp_q <= ovf_a_q;
      end
      if (finish) busy_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fib_seq_display.sv
// Directed bench for fib_seq_display with a short dwell for run mode.
module tb_fib_seq_display;

  localparam int NW = 5;
  localparam int RW = 19;
  localparam int DG = 6;
  localparam int DW = 4;

  logic            clk, reset, start, run_mode, busy, done_tick, overflow;
  logic [NW-1:0]   n, leds;
  logic [8*DG-1:0] sseg;

  int checks = 0;
  int errors = 0;

  logic [8*DG-1:0] snap [0:1023];
  int lat, nd;
  logic busy_acc, ovf_acc;

  localparam logic [47:0] DARK = {6{8'hFF}};
  localparam logic [47:0] DASH = {6{8'hBF}};

  fib_seq_display #(.N_W(NW), .RES_W(RW), .DIGITS(DG), .DWELL(DW), .BLANK_LZ(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .run_mode  (run_mode),
    .n         (n),
    .sseg      (sseg),
    .leds      (leds),
    .busy      (busy),
    .done_tick (done_tick),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] one_digit(input logic [7:0] d0);
    return {{5{8'hFF}}, d0};
  endfunction

  // Press (falling edge), then run ncyc cycles recording display and done ticks.
  // A second press is injected at cycle poke (n is also changed then).
  task automatic go(input int nv, input logic mode, input int poke, input logic hold,
                    input int ncyc);
    n = NW'(nv);
    run_mode = mode;
    start = 1'b0;
    step();
    busy_acc = busy;
    ovf_acc  = overflow;
    if (!hold) start = 1'b1;
    lat = -1;
    nd  = 0;
    for (int c = 1; c <= ncyc; c++) begin
      if (c == poke) begin
        start = 1'b0;
        n = 5'd3;
      end else if (c == poke + 1) begin
        start = 1'b1;
      end
      step();
      snap[c] = sseg;
      if (done_tick) begin
        nd++;
        if (lat < 0) lat = c;
      end
    end
    start = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b1;
    run_mode = 1'b0;
    n = '0;
    repeat (3) step();
    chk("rst_sseg", sseg, DARK);
    chk("rst_busy", 48'(busy), 48'd0);
    chk("rst_done", 48'(done_tick), 48'd0);
    chk("rst_ovf", 48'(overflow), 48'd0);
    reset = 1'b0;
    step();
    n = 5'd10;
    #1;
    chk("leds", 48'(leds), 48'd10);

    // F(10) = 55
    go(10, 1'b0, -1, 1'b0, 40);
    chk("n10_lat", 48'(lat), 48'd31);
    chk("n10_ndone", 48'(nd), 48'd1);
    chk("n10_busy_acc", 48'(busy_acc), 48'd1);
    chk("n10_atomic", snap[20], DARK);
    chk("n10_sseg", sseg, {{4{8'hFF}}, 8'h92, 8'h92});
    chk("n10_ovf", 48'(overflow), 48'd0);
    chk("n10_busy_end", 48'(busy), 48'd0);

    // F(0) = 0, digit 0 stays lit
    go(0, 1'b0, -1, 1'b0, 30);
    chk("n0_lat", 48'(lat), 48'd21);
    chk("n0_sseg", sseg, one_digit(8'hC0));

    // F(30) overflows 19 bits
    go(30, 1'b0, -1, 1'b0, 60);
    chk("n30_lat", 48'(lat), 48'd51);
    chk("n30_ndone", 48'(nd), 48'd1);
    chk("n30_sseg", sseg, DASH);
    chk("n30_ovf", 48'(overflow), 48'd1);

    // next accept clears overflow; old dashes held until LOAD
    go(5, 1'b0, -1, 1'b0, 30);
    chk("n5_ovf_acc", 48'(ovf_acc), 48'd0);
    chk("n5_hold_old", snap[10], DASH);
    chk("n5_sseg", sseg, one_digit(8'h92));
    chk("n5_ovf", 48'(overflow), 48'd0);

    // F(29) = 514229, largest in range
    go(29, 1'b0, -1, 1'b0, 55);
    chk("n29_lat", 48'(lat), 48'd50);
    chk("n29_sseg", sseg, {8'h92, 8'hF9, 8'h99, 8'hA4, 8'hA4, 8'h90});
    chk("n29_ovf", 48'(overflow), 48'd0);

    // second press during CONV is dropped, n latched at accept
    go(10, 1'b0, 20, 1'b0, 40);
    chk("dup_lat", 48'(lat), 48'd31);
    chk("dup_ndone", 48'(nd), 48'd1);
    chk("dup_sseg", sseg, {{4{8'hFF}}, 8'h92, 8'h92});

    // run mode n=4: frames 0,1,1,2,3 every 25 cycles starting at cycle 21
    go(4, 1'b1, -1, 1'b0, 130);
    chk("run_pre", snap[20], {{4{8'hFF}}, 8'h92, 8'h92});
    chk("run_f0", snap[21], one_digit(8'hC0));
    chk("run_f0_hold", snap[45], one_digit(8'hC0));
    chk("run_f1", snap[46], one_digit(8'hF9));
    chk("run_f1_hold", snap[70], one_digit(8'hF9));
    chk("run_f2", snap[71], one_digit(8'hF9));
    chk("run_f2_hold", snap[95], one_digit(8'hF9));
    chk("run_f3", snap[96], one_digit(8'hA4));
    chk("run_f3_hold", snap[120], one_digit(8'hA4));
    chk("run_f4", snap[121], one_digit(8'hB0));
    chk("run_lat", 48'(lat), 48'd121);
    chk("run_ndone", 48'(nd), 48'd1);
    chk("run_busy_end", 48'(busy), 48'd0);

    // run mode n=31 stops at first overflowed frame, index 30
    go(31, 1'b1, -1, 1'b0, 780);
    chk("runovf_f29", snap[746], {8'h92, 8'hF9, 8'h99, 8'hA4, 8'hA4, 8'h90});
    chk("runovf_lat", 48'(lat), 48'd771);
    chk("runovf_ndone", 48'(nd), 48'd1);
    chk("runovf_sseg", sseg, DASH);
    chk("runovf_ovf", 48'(overflow), 48'd1);

    // start held low gives one request only
    go(5, 1'b0, -1, 1'b1, 80);
    chk("hold_lat", 48'(lat), 48'd26);
    chk("hold_ndone", 48'(nd), 48'd1);
    step();

    // reset in the middle of CONV
    n = 5'd10;
    run_mode = 1'b0;
    start = 1'b0;
    step();
    start = 1'b1;
    repeat (20) step();
    chk("mid_busy_pre", 48'(busy), 48'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_sseg", sseg, DARK);
    chk("mid_rst_busy", 48'(busy), 48'd0);
    step();
    reset = 1'b0;
    step();
    go(0, 1'b0, -1, 1'b0, 30);
    chk("post_rst_lat", 48'(lat), 48'd21);
    chk("post_rst_sseg", sseg, one_digit(8'hC0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
